// File: rtl/payload_filter_if.sv
// Payload/header input stream and filtered valid/ready output stream of payload_filter.
interface payload_filter_if;
    logic        iHeader_A_valid;
    logic [47:0] iHeader_A;
    logic        iHeader_B_valid;
    logic [47:0] iHeader_B;
    logic        iHeader_C_valid;
    logic [15:0] iHeader_C;
    logic        iPayload_valid;
    logic [63:0] iPayload;
    logic        iSop;
    logic        iEop;
    logic [7:0]  iByte_enable;
    logic        oValid;
    logic        iReady;
    logic [63:0] oPayload;
    logic [7:0]  oByte_enable;
    logic        oSop;
    logic        oEop;
    logic        oErr;

    modport slave (
        input  iHeader_A_valid, iHeader_A, iHeader_B_valid, iHeader_B,
               iHeader_C_valid, iHeader_C, iPayload_valid, iPayload,
               iSop, iEop, iByte_enable, iReady,
        output oValid, oPayload, oByte_enable, oSop, oEop, oErr
    );

    modport master (
        output iHeader_A_valid, iHeader_A, iHeader_B_valid, iHeader_B,
               iHeader_C_valid, iHeader_C, iPayload_valid, iPayload,
               iSop, iEop, iByte_enable, iReady,
        input  oValid, oPayload, oByte_enable, oSop, oEop, oErr
    );
endinterface

// File: rtl/payload_filter.sv
// Per-packet pass/drop on dest MAC + ethertype, passed payload buffered in a show-ahead cut-through FIFO.
// Optional: define PAYLOAD_FILTER_BCAST_EN to also accept dest MAC FF:FF:FF:FF:FF:FF.
module payload_filter #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             iClk,
    input  logic             iReset,
    payload_filter_if.slave  bus,
    input  logic [47:0]      iMatch_mac,
    input  logic [15:0]      iMatch_type,
    output logic [47:0]      oSrc_mac,
    output logic [CNT_W-1:0] oPass_count,
    output logic [CNT_W-1:0] oDrop_count,
    output logic             oOverflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH-1);

    typedef enum logic [1:0] {IDLE, HDR, PASS, DROP} state_t;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  be;
        logic        sop;
        logic        eop;
        logic        err;
    } ent_t;

    state_t        r_state, w_state_nx;
    ent_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_mac_hit, r_first;
    logic [47:0]   r_src_b;
    logic          w_mac_hit, w_match, w_first, w_first_nx;
    logic          w_pass_mode, w_drop_mode, w_wr_en, w_pop;
    logic          w_pass_inc, w_drop_inc, w_ovf_set, w_src_upd;
    ent_t          w_wr_ent, w_rd_ent;

`ifdef PAYLOAD_FILTER_BCAST_EN
    assign w_mac_hit = (bus.iHeader_A == iMatch_mac) || (bus.iHeader_A == 48'hFFFF_FFFF_FFFF);
`else
    assign w_mac_hit = (bus.iHeader_A == iMatch_mac);
`endif
    assign w_match = r_mac_hit && (bus.iHeader_C == iMatch_type);
    // r_first is only meaningful once a packet has been accepted; in HDR the next write is always the first
    assign w_first = (r_state == HDR) || r_first;

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) r_state <= IDLE;
        else         r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_first_nx  = r_first;
        w_pass_mode = 1'b0;
        w_drop_mode = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_ent    = '0;
        w_pass_inc  = 1'b0;
        w_drop_inc  = 1'b0;
        w_ovf_set   = 1'b0;
        w_src_upd   = 1'b0;
        case (r_state)
            IDLE: if (bus.iSop) w_state_nx = HDR;
            HDR: begin
                if (bus.iSop) begin
                    w_drop_inc = 1'b1;
                end else if (bus.iHeader_C_valid) begin
                    if (w_match) begin
                        w_pass_mode = 1'b1;
                        w_src_upd   = 1'b1;
                        w_first_nx  = 1'b1;
                        w_state_nx  = PASS;
                    end else begin
                        w_drop_mode = 1'b1;
                        w_state_nx  = DROP;
                    end
                end else if (bus.iEop) begin
                    w_drop_inc = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            PASS: begin
                if (bus.iSop) begin
                    // close the open packet so the consumer never sees a dangling sop
                    if (!r_first) begin
                        w_wr_en      = 1'b1;
                        w_wr_ent.eop = 1'b1;
                        w_wr_ent.err = 1'b1;
                    end
                    w_drop_inc = 1'b1;
                    w_state_nx = HDR;
                end else begin
                    w_pass_mode = 1'b1;
                end
            end
            default: begin
                if (bus.iSop) begin
                    w_drop_inc = 1'b1;
                    w_state_nx = HDR;
                end else begin
                    w_drop_mode = 1'b1;
                end
            end
        endcase

        if (w_pass_mode) begin
            if (bus.iPayload_valid) begin
                w_wr_ent.data = bus.iPayload;
                w_wr_ent.be   = bus.iByte_enable;
                w_wr_ent.sop  = w_first;
                if (w_first && r_count == FULL) begin
                    w_ovf_set   = 1'b1;
                    w_state_nx  = DROP;
                    w_drop_mode = 1'b1;
                end else if (bus.iEop) begin
                    w_wr_en      = 1'b1;
                    w_wr_ent.eop = 1'b1;
                    w_pass_inc   = 1'b1;
                    w_first_nx   = 1'b0;
                    w_state_nx   = IDLE;
                end else if (r_count < LAST) begin
                    w_wr_en    = 1'b1;
                    w_first_nx = 1'b0;
                end else begin
                    // last free slot: truncate here so a full FIFO never holds an open packet
                    w_wr_en      = 1'b1;
                    w_wr_ent.eop = 1'b1;
                    w_wr_ent.err = 1'b1;
                    w_ovf_set    = 1'b1;
                    w_first_nx   = 1'b0;
                    w_state_nx   = DROP;
                end
            end else if (bus.iEop) begin
                if (!w_first) begin
                    w_wr_en      = 1'b1;
                    w_wr_ent.eop = 1'b1;
                    w_wr_ent.err = 1'b1;
                end
                w_drop_inc = 1'b1;
                w_state_nx = IDLE;
            end
        end

        if (w_drop_mode && bus.iEop) begin
            w_drop_inc = 1'b1;
            w_state_nx = IDLE;
        end
    end

    assign w_pop    = bus.oValid && bus.iReady;
    assign w_rd_ent = r_mem[r_rd_ptr];

    always_ff @(posedge iClk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_ent;
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_mac_hit   <= 1'b0;
            r_first     <= 1'b0;
            r_src_b     <= '0;
            oSrc_mac    <= '0;
            oPass_count <= '0;
            oDrop_count <= '0;
            oOverflow   <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_wr_en} - {{AW{1'b0}}, w_pop};
            if (bus.iSop && bus.iHeader_A_valid) r_mac_hit <= w_mac_hit;
            r_first <= w_first_nx;
            if (bus.iHeader_B_valid) r_src_b <= bus.iHeader_B;
            if (w_src_upd) oSrc_mac <= bus.iHeader_B_valid ? bus.iHeader_B : r_src_b;
            if (w_pass_inc && oPass_count != '1) oPass_count <= oPass_count + 1'b1;
            if (w_drop_inc && oDrop_count != '1) oDrop_count <= oDrop_count + 1'b1;
            if (w_ovf_set) oOverflow <= 1'b1;
        end
    end

    assign bus.oValid       = (r_count != '0);
    assign bus.oPayload     = bus.oValid ? w_rd_ent.data : '0;
    assign bus.oByte_enable = bus.oValid ? w_rd_ent.be   : '0;
    assign bus.oSop         = bus.oValid && w_rd_ent.sop;
    assign bus.oEop         = bus.oValid && w_rd_ent.eop;
    assign bus.oErr         = bus.oValid && w_rd_ent.err;
endmodule

// File: tb/tb_payload_filter.sv
// Randomized + directed bench for payload_filter against a queue-based packet reference model.
module tb_payload_filter;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic             iClk = 1'b0;
    logic             iReset;
    logic [47:0]      iMatch_mac;
    logic [15:0]      iMatch_type;
    logic [47:0]      oSrc_mac;
    logic [CNT_W-1:0] oPass_count, oDrop_count;
    logic             oOverflow;

    payload_filter_if bus();

    payload_filter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .iClk(iClk), .iReset(iReset), .bus(bus.slave),
        .iMatch_mac(iMatch_mac), .iMatch_type(iMatch_type),
        .oSrc_mac(oSrc_mac), .oPass_count(oPass_count),
        .oDrop_count(oDrop_count), .oOverflow(oOverflow)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  be;
        logic        sop, eop, err;
    } ment_t;

    // reference model: expected FIFO contents + packet progress
    ment_t       mq[$];
    int          m_pass, m_drop;
    bit          m_ovf;
    logic [47:0] m_src, m_b;
    bit          m_hit, m_wrote;
    int          m_phase;   // 0 between packets, 1 awaiting ethertype, 2 accepting, 3 discarding

    int n_vec = 0, n_err = 0;

    // stimulus for the next cycle
    bit          s_rst, s_sop, s_av, s_bv, s_cv, s_pv, s_eop, s_ready, rnd_ready;
    logic [47:0] s_a, s_b;
    logic [15:0] s_c;
    logic [63:0] s_pl;
    logic [7:0]  s_be;
    int          p_ready;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        s_sop = 0; s_av = 0; s_bv = 0; s_cv = 0; s_pv = 0; s_eop = 0;
        s_a = '0; s_b = '0; s_c = '0; s_pl = '0; s_be = '0;
    endtask

    function automatic ment_t mk(input logic [63:0] d, input logic [7:0] be,
                                 input bit sop, input bit eop, input bit err);
        ment_t e;
        e.d = d; e.be = be; e.sop = sop; e.eop = eop; e.err = err;
        return e;
    endfunction

    function automatic bit mac_ok(input logic [47:0] a);
`ifdef PAYLOAD_FILTER_BCAST_EN
        return (a == iMatch_mac) || (a == 48'hFFFF_FFFF_FFFF);
`else
        return a == iMatch_mac;
`endif
    endfunction

    task automatic model_cycle();
        int sz;
        if (!s_rst) begin
            mq.delete(); m_pass = 0; m_drop = 0; m_ovf = 0;
            m_src = '0; m_b = '0; m_phase = 0; m_wrote = 0;
            return;
        end
        sz = mq.size();
        if (sz > 0 && s_ready) void'(mq.pop_front());
        if (s_bv) m_b = s_b;
        if (s_sop) begin
            if (m_phase == 2 && m_wrote) mq.push_back(mk(64'h0, 8'h0, 0, 1, 1));
            if (m_phase != 0) m_drop++;
            m_hit = mac_ok(s_a); m_phase = 1; m_wrote = 0;
            return;
        end
        if (m_phase == 1) begin
            if (s_cv) begin
                if (m_hit && s_c == iMatch_type) begin m_phase = 2; m_src = m_b; end
                else m_phase = 3;
            end else if (s_eop) begin
                m_drop++; m_phase = 0;
            end
        end
        if (m_phase == 2) begin
            if (s_pv) begin
                if (!m_wrote && sz == DEPTH) begin
                    m_ovf = 1; m_phase = 3;
                end else if (s_eop) begin
                    mq.push_back(mk(s_pl, s_be, !m_wrote, 1, 0)); m_pass++; m_phase = 0;
                end else if (sz < DEPTH - 1) begin
                    mq.push_back(mk(s_pl, s_be, !m_wrote, 0, 0)); m_wrote = 1;
                end else begin
                    mq.push_back(mk(s_pl, s_be, !m_wrote, 1, 1)); m_ovf = 1; m_phase = 3;
                end
            end else if (s_eop) begin
                if (m_wrote) mq.push_back(mk(64'h0, 8'h0, 0, 1, 1));
                m_drop++; m_phase = 0;
            end
        end
        if (m_phase == 3 && s_eop) begin
            m_drop++; m_phase = 0;
        end
    endtask

    task automatic step();
        @(negedge iClk);
        if (rnd_ready) s_ready = ($urandom_range(1, 100) <= p_ready);
        iReset              = s_rst;
        bus.iSop            = s_sop;
        bus.iHeader_A_valid = s_av;  bus.iHeader_A = s_a;
        bus.iHeader_B_valid = s_bv;  bus.iHeader_B = s_b;
        bus.iHeader_C_valid = s_cv;  bus.iHeader_C = s_c;
        bus.iPayload_valid  = s_pv;  bus.iPayload  = s_pl;
        bus.iEop            = s_eop; bus.iByte_enable = s_be;
        bus.iReady          = s_ready;
        #1;
        if (!s_rst) model_cycle();
        chk("valid", 64'(bus.oValid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("data", bus.oPayload, mq[0].d);
            chk("ctl", 64'({bus.oByte_enable, bus.oSop, bus.oEop, bus.oErr}),
                64'({mq[0].be, mq[0].sop, mq[0].eop, mq[0].err}));
        end
        chk("pass_cnt", 64'(oPass_count), 64'(m_pass));
        chk("drop_cnt", 64'(oDrop_count), 64'(m_drop));
        chk("overflow", 64'(oOverflow), 64'(m_ovf));
        chk("src_mac", 64'(oSrc_mac), 64'(m_src));
        if (s_rst) model_cycle();
    endtask

    task automatic idle(input int n);
        clr();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic put_word(input int w, input int nw, input bit no_eop);
        s_pv  = 1;
        s_pl  = {$urandom, $urandom};
        s_eop = (w == nw - 1) && !no_eop;
        s_be  = s_eop ? (8'hFF >> $urandom_range(0, 7)) : 8'hFF;
    endtask

    task automatic send_pkt(input logic [47:0] da, input logic [15:0] et, input int nw,
                            input bit no_eop, input int gap_pct);
        int w = 0;
        clr(); s_sop = 1; s_av = 1; s_a = da; step();
        clr(); s_bv = 1; s_b = 48'({$urandom, $urandom}); step();
        clr(); s_cv = 1; s_c = et;
        if (nw == 0) s_eop = !no_eop;
        else if ($urandom_range(0, 1) == 1) begin put_word(w, nw, no_eop); w++; end
        step();
        while (w < nw) begin
            clr();
            if ($urandom_range(1, 100) > gap_pct) begin put_word(w, nw, no_eop); w++; end
            step();
        end
        clr();
    endtask

    initial begin
        iMatch_mac = 48'h0200_1122_3344;
        iMatch_type = 16'h0800;
        rnd_ready = 0; s_ready = 1; p_ready = 100;
        clr();
        s_rst = 0;
        idle(3);
        s_rst = 1;
        idle(2);

        // basic pass, 3 words
        send_pkt(iMatch_mac, 16'h0800, 3, 0, 0);
        idle(5);
        chk("t1_pass", 64'(oPass_count), 64'd1);

        // ethertype mismatch
        send_pkt(iMatch_mac, 16'h0806, 3, 0, 0);
        idle(3);
        chk("t2_drop", 64'(oDrop_count), 64'd1);

        // overflow truncation with stalled consumer
        s_ready = 0;
        send_pkt(iMatch_mac, 16'h0800, 20, 0, 0);
        idle(3);
        chk("t3_ovf", 64'(oOverflow), 64'd1);
        chk("t3_pass", 64'(oPass_count), 64'd1);
        s_ready = 1;
        idle(DEPTH + 4);

        // abort by new sop, then a clean packet
        send_pkt(iMatch_mac, 16'h0800, 2, 1, 0);
        send_pkt(iMatch_mac, 16'h0800, 4, 0, 0);
        idle(8);

        // reset mid-packet; trailing words ignored
        clr(); s_sop = 1; s_av = 1; s_a = iMatch_mac; step();
        clr(); s_bv = 1; s_b = 48'hAABB_CCDD_EEFF; step();
        clr(); s_cv = 1; s_c = 16'h0800; put_word(0, 4, 0); step();
        clr(); put_word(1, 4, 0); step();
        clr(); s_rst = 0; step();
        s_rst = 1;
        clr(); put_word(2, 4, 0); step();
        clr(); put_word(3, 4, 0); step();
        idle(2);
        chk("t5_pass", 64'(oPass_count), 64'd0);
        chk("t5_valid", 64'(bus.oValid), 64'd0);
        send_pkt(iMatch_mac, 16'h0800, 2, 0, 0);
        idle(4);

        // broadcast dest
        send_pkt(48'hFFFF_FFFF_FFFF, 16'h0800, 3, 0, 0);
        idle(5);

        // random traffic
        rnd_ready = 1;
        for (int p = 0; p < 300; p++) begin
            logic [47:0] da;
            int r;
            p_ready = ($urandom_range(0, 3) == 0) ? 10 : 80;
            r = $urandom_range(0, 9);
            da = (r < 6) ? iMatch_mac : (r < 8) ? 48'hFFFF_FFFF_FFFF : 48'({$urandom, $urandom});
            send_pkt(da, ($urandom_range(0, 4) == 0) ? 16'h0806 : 16'h0800,
                     $urandom_range(0, 20), ($urandom_range(0, 9) == 0), 20);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        rnd_ready = 0; s_ready = 1;
        idle(DEPTH + 8);
        chk("drained", 64'(bus.oValid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
